// File: rtl/bus_width_bridge_pkg.sv
// Shared types and width helpers for the narrow-CPU to wide-peripheral bus bridge.
package bus_width_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_REQ = 2'd1,
      RD_REQ = 2'd2
   } bwb_state_e;

   function automatic int bwb_ratio(input int wide_w, input int narrow_w);
      return wide_w / narrow_w;
   endfunction

   // A one-entry index still needs a one-bit field.
   function automatic int bwb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bwb_word_buffer.sv
// Staging (write assembly) and snapshot (atomic read) wide words, split into
// NARROW_W slices with slice 0 at the most significant end.
module bwb_word_buffer #(
   parameter int NARROW_W = 16,
   parameter int RATIO    = 2,
   parameter int SUB_W    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stage_we_i,
   input  logic [SUB_W-1:0]          stage_idx_i,
   input  logic [NARROW_W-1:0]       stage_data_i,
   output logic [NARROW_W*RATIO-1:0] stage_word_o,
   input  logic                      snap_we_i,
   input  logic [NARROW_W*RATIO-1:0] snap_data_i,
   input  logic [SUB_W-1:0]          rd_idx_i,
   output logic [NARROW_W-1:0]       rd_slice_o
);

   localparam int WIDE_W = NARROW_W * RATIO;

   logic [WIDE_W-1:0] stage_q, stage_d;
   logic [WIDE_W-1:0] snap_q, snap_d;

   // Next-state words; outputs expose the merged view so the top can register
   // a commit or a read-after-ack without an extra cycle.
   always_comb begin
      stage_d = stage_q;
      snap_d  = snap_q;
      if (stage_we_i) begin
         stage_d[WIDE_W-1-int'(stage_idx_i)*NARROW_W -: NARROW_W] = stage_data_i;
      end else begin
         stage_d = stage_q;
      end
      if (snap_we_i) begin
         snap_d = snap_data_i;
      end else begin
         snap_d = snap_q;
      end
      stage_word_o = stage_d;
      rd_slice_o   = snap_d[WIDE_W-1-int'(rd_idx_i)*NARROW_W -: NARROW_W];
   end

   // Word storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= {WIDE_W{1'b0}};
         snap_q  <= {WIDE_W{1'b0}};
      end else begin
         stage_q <= stage_d;
         snap_q  <= snap_d;
      end
   end

endmodule

// File: rtl/bus_width_bridge.sv
// Narrow CPU port to wide peripheral register bridge with staged writes and
// snapshot reads. Optional ack timeout: define BUS_WIDTH_BRIDGE_TIMEOUT_EN.
module bus_width_bridge
   import bus_width_bridge_pkg::*;
#(
   parameter int NARROW_W   = 16,
   parameter int WIDE_W     = 32,
   parameter int NREGS      = 4,
   parameter int TMO_CYCLES = 255
) (
   input  logic                                                    clk,
   input  logic                                                    reset,
   input  logic [bwb_idx_w(NREGS)+bwb_idx_w(WIDE_W/NARROW_W)-1:0]  cpu_addr,
   input  logic                                                    cpu_wr,
   input  logic                                                    cpu_rd,
   input  logic [NARROW_W-1:0]                                     cpu_wdata,
   output logic [NARROW_W-1:0]                                     cpu_rdata,
   output logic                                                    cpu_rvalid,
   output logic                                                    cpu_busy,
   output logic                                                    cpu_err,
   output logic                                                    per_req,
   output logic                                                    per_we,
   output logic [bwb_idx_w(NREGS)-1:0]                             per_addr,
   output logic [WIDE_W-1:0]                                       per_wdata,
   input  logic                                                    per_ack,
   input  logic [WIDE_W-1:0]                                       per_rdata
);

   localparam int RATIO  = bwb_ratio(WIDE_W, NARROW_W);
   localparam int SUB_W  = bwb_idx_w(RATIO);
   localparam int REG_W  = bwb_idx_w(NREGS);
   localparam int ADDR_W = REG_W + SUB_W;
   localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(RATIO - 1);

   bwb_state_e          state_q, state_d;
   logic                per_req_q, per_req_d;
   logic                per_we_q, per_we_d;
   logic [REG_W-1:0]    per_addr_q, per_addr_d;
   logic [WIDE_W-1:0]   per_wdata_q, per_wdata_d;
   logic [NARROW_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic                cpu_rvalid_q, cpu_rvalid_d;
   logic                cpu_busy_q, cpu_busy_d;
   logic                cpu_err_q, cpu_err_d;

   logic [REG_W-1:0]    reg_sel_s;
   logic [SUB_W-1:0]    sub_sel_s;
   logic                stage_we_s;
   logic [WIDE_W-1:0]   stage_word_s;
   logic                snap_we_s;
   logic [WIDE_W-1:0]   snap_data_s;
   logic [SUB_W-1:0]    rd_idx_s;
   logic [NARROW_W-1:0] rd_slice_s;
   logic                tmo_hit_s;

   assign reg_sel_s = cpu_addr[ADDR_W-1:SUB_W];
   assign sub_sel_s = cpu_addr[SUB_W-1:0];

   bwb_word_buffer #(
      .NARROW_W (NARROW_W),
      .RATIO    (RATIO),
      .SUB_W    (SUB_W)
   ) u_buf (
      .clk          (clk),
      .reset        (reset),
      .stage_we_i   (stage_we_s),
      .stage_idx_i  (sub_sel_s),
      .stage_data_i (cpu_wdata),
      .stage_word_o (stage_word_s),
      .snap_we_i    (snap_we_s),
      .snap_data_i  (snap_data_s),
      .rd_idx_i     (rd_idx_s),
      .rd_slice_o   (rd_slice_s)
   );

`ifdef BUS_WIDTH_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;

   // Cycles spent waiting for ack; restarts whenever the bridge is idle.
   always_comb begin
      tmo_d = tmo_q;
      if (state_q == IDLE) begin
         tmo_d = {TMO_W{1'b0}};
      end else begin
         tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= {TMO_W{1'b0}};
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign tmo_hit_s = (tmo_q == TMO_W'(TMO_CYCLES - 1));
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state and output logic; ack wins over a same-cycle timeout.
   always_comb begin
      state_d      = state_q;
      per_req_d    = per_req_q;
      per_we_d     = per_we_q;
      per_addr_d   = per_addr_q;
      per_wdata_d  = per_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      cpu_rvalid_d = 1'b0;
      cpu_busy_d   = cpu_busy_q;
      cpu_err_d    = cpu_err_q;
      stage_we_s   = 1'b0;
      snap_we_s    = 1'b0;
      snap_data_s  = per_rdata;
      rd_idx_s     = sub_sel_s;
      case (state_q)
         IDLE: begin
            if (cpu_wr) begin
               stage_we_s = 1'b1;
               if (sub_sel_s == LAST_SUB) begin
                  per_req_d   = 1'b1;
                  per_we_d    = 1'b1;
                  per_addr_d  = reg_sel_s;
                  per_wdata_d = stage_word_s;
                  cpu_busy_d  = 1'b1;
                  state_d     = WR_REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (cpu_rd) begin
               if (sub_sel_s == {SUB_W{1'b0}}) begin
                  per_req_d  = 1'b1;
                  per_we_d   = 1'b0;
                  per_addr_d = reg_sel_s;
                  cpu_busy_d = 1'b1;
                  state_d    = RD_REQ;
               end else begin
                  cpu_rdata_d  = rd_slice_s;
                  cpu_rvalid_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WR_REQ, RD_REQ: begin
            if (per_ack || tmo_hit_s) begin
               per_req_d  = 1'b0;
               cpu_busy_d = 1'b0;
               state_d    = IDLE;
               if (!per_ack) begin
                  cpu_err_d   = 1'b1;
                  snap_data_s = {WIDE_W{1'b1}};
               end else begin
                  snap_data_s = per_rdata;
               end
               if (state_q == RD_REQ) begin
                  snap_we_s    = 1'b1;
                  rd_idx_s     = {SUB_W{1'b0}};
                  cpu_rdata_d  = rd_slice_s;
                  cpu_rvalid_d = 1'b1;
               end else begin
                  snap_we_s = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d    = IDLE;
            per_req_d  = 1'b0;
            cpu_busy_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         per_req_q    <= 1'b0;
         per_we_q     <= 1'b0;
         per_addr_q   <= {REG_W{1'b0}};
         per_wdata_q  <= {WIDE_W{1'b0}};
         cpu_rdata_q  <= {NARROW_W{1'b0}};
         cpu_rvalid_q <= 1'b0;
         cpu_busy_q   <= 1'b0;
         cpu_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_req_q    <= per_req_d;
         per_we_q     <= per_we_d;
         per_addr_q   <= per_addr_d;
         per_wdata_q  <= per_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_busy_q   <= cpu_busy_d;
         cpu_err_q    <= cpu_err_d;
      end
   end

   assign per_req    = per_req_q;
   assign per_we     = per_we_q;
   assign per_addr   = per_addr_q;
   assign per_wdata  = per_wdata_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_busy   = cpu_busy_q;
   assign cpu_err    = cpu_err_q;

endmodule

// File: tb/tb_bus_width_bridge.sv
// Directed self-checking bench for bus_width_bridge (16-bit CPU, 32-bit peripheral, 4 registers).
module tb_bus_width_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cpu_addr;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        cpu_busy;
   logic        cpu_err;
   logic        per_req;
   logic        per_we;
   logic [1:0]  per_addr;
   logic [31:0] per_wdata;
   logic        per_ack;
   logic [31:0] per_rdata;

   int checks = 0;
   int errors = 0;

   bus_width_bridge #(
      .NARROW_W   (16),
      .WIDE_W     (32),
      .NREGS      (4),
      .TMO_CYCLES (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wr     (cpu_wr),
      .cpu_rd     (cpu_rd),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .cpu_busy   (cpu_busy),
      .cpu_err    (cpu_err),
      .per_req    (per_req),
      .per_we     (per_we),
      .per_addr   (per_addr),
      .per_wdata  (per_wdata),
      .per_ack    (per_ack),
      .per_rdata  (per_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".per_req"},    {31'd0, per_req},    32'd0);
      check({tag, ".per_we"},     {31'd0, per_we},     32'd0);
      check({tag, ".per_addr"},   {30'd0, per_addr},   32'd0);
      check({tag, ".per_wdata"},  per_wdata,           32'd0);
      check({tag, ".cpu_busy"},   {31'd0, cpu_busy},   32'd0);
      check({tag, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
      check({tag, ".cpu_rdata"},  {16'd0, cpu_rdata},  32'd0);
      check({tag, ".cpu_err"},    {31'd0, cpu_err},    32'd0);
   endtask

   // One-cycle write strobe followed by the edge that samples it.
   task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wr    = 1'b1;
      tick();
      cpu_wr    = 1'b0;
   endtask

   task automatic cpu_read(input logic [2:0] a);
      cpu_addr = a;
      cpu_rd   = 1'b1;
      tick();
      cpu_rd   = 1'b0;
   endtask

   task automatic ack_cycle(input logic [31:0] d);
      per_ack   = 1'b1;
      per_rdata = d;
      tick();
      per_ack   = 1'b0;
      per_rdata = 32'd0;
   endtask

   initial begin
      reset     = 1'b1;
      cpu_addr  = 3'd0;
      cpu_wr    = 1'b0;
      cpu_rd    = 1'b0;
      cpu_wdata = 16'd0;
      per_ack   = 1'b0;
      per_rdata = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      check_all_zero("reset");

      // Staged write: first slice alone causes no peripheral activity.
      cpu_write(3'd2, 16'h1234);
      check("wr_stage.per_req", {31'd0, per_req}, 32'd0);
      check("wr_stage.busy", {31'd0, cpu_busy}, 32'd0);
      cpu_write(3'd3, 16'h5678);
      check("wr_commit.per_req", {31'd0, per_req}, 32'd1);
      check("wr_commit.per_we", {31'd0, per_we}, 32'd1);
      check("wr_commit.per_addr", {30'd0, per_addr}, 32'd1);
      check("wr_commit.per_wdata", per_wdata, 32'h1234_5678);
      check("wr_busy1", {31'd0, cpu_busy}, 32'd1);
      tick();
      check("wr_busy2", {31'd0, cpu_busy}, 32'd1);
      tick();
      check("wr_busy3", {31'd0, cpu_busy}, 32'd1);
      tick();
      check("wr_busy4", {31'd0, cpu_busy}, 32'd1);
      check("wr_hold.per_wdata", per_wdata, 32'h1234_5678);
      check("wr_hold.per_req", {31'd0, per_req}, 32'd1);
      ack_cycle(32'd0);
      check("wr_done.per_req", {31'd0, per_req}, 32'd0);
      check("wr_done.busy", {31'd0, cpu_busy}, 32'd0);
      check("wr_done.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      tick();
      check("wr_once.per_req", {31'd0, per_req}, 32'd0);

      // Wide read, then second slice served from the snapshot.
      cpu_read(3'd4);
      check("rd_req.per_req", {31'd0, per_req}, 32'd1);
      check("rd_req.per_we", {31'd0, per_we}, 32'd0);
      check("rd_req.per_addr", {30'd0, per_addr}, 32'd2);
      check("rd_req.busy", {31'd0, cpu_busy}, 32'd1);
      check("rd_req.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      ack_cycle(32'hCAFE_BABE);
      check("rd_ack.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("rd_ack.rdata", {16'd0, cpu_rdata}, 32'h0000_CAFE);
      check("rd_ack.per_req", {31'd0, per_req}, 32'd0);
      check("rd_ack.busy", {31'd0, cpu_busy}, 32'd0);
      cpu_read(3'd5);
      check("rd_snap.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("rd_snap.rdata", {16'd0, cpu_rdata}, 32'h0000_BABE);
      check("rd_snap.per_req", {31'd0, per_req}, 32'd0);
      tick();
      check("rd_snap.rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);

      // Accesses while busy are ignored.
      cpu_write(3'd0, 16'hAAAA);
      cpu_write(3'd1, 16'hBBBB);
      check("commit2.per_wdata", per_wdata, 32'hAAAA_BBBB);
      check("commit2.per_addr", {30'd0, per_addr}, 32'd0);
      cpu_write(3'd0, 16'h5555);
      cpu_read(3'd5);
      check("busy_rd.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      check("busy_wr.per_wdata", per_wdata, 32'hAAAA_BBBB);
      ack_cycle(32'd0);
      cpu_write(3'd7, 16'hCCCC);
      check("commit3.per_wdata", per_wdata, 32'hAAAA_CCCC);
      check("commit3.per_addr", {30'd0, per_addr}, 32'd3);
      ack_cycle(32'd0);

      // Simultaneous write and read: only the write happens.
      cpu_addr  = 3'd0;
      cpu_wdata = 16'h1111;
      cpu_wr    = 1'b1;
      cpu_rd    = 1'b1;
      tick();
      cpu_wr    = 1'b0;
      cpu_rd    = 1'b0;
      check("wr_rd.per_req", {31'd0, per_req}, 32'd0);
      check("wr_rd.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      cpu_write(3'd1, 16'h2222);
      check("wr_rd.per_wdata", per_wdata, 32'h1111_2222);
      check("wr_rd.per_we", {31'd0, per_we}, 32'd1);
      ack_cycle(32'd0);

      // Stray ack while idle leaves snapshot untouched.
      ack_cycle(32'hDEAD_BEEF);
      check("idle_ack.per_req", {31'd0, per_req}, 32'd0);
      check("idle_ack.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      cpu_read(3'd5);
      check("idle_ack.snap", {16'd0, cpu_rdata}, 32'h0000_BABE);

      // Unacked read: aborts after 8 cycles with timeout, otherwise waits.
      cpu_read(3'd2);
      check("tmo.per_req_start", {31'd0, per_req}, 32'd1);
      repeat (7) tick();
      check("tmo.per_req_c8", {31'd0, per_req}, 32'd1);
      tick();
`ifdef BUS_WIDTH_BRIDGE_TIMEOUT_EN
      check("tmo.per_req_drop", {31'd0, per_req}, 32'd0);
      check("tmo.err", {31'd0, cpu_err}, 32'd1);
      check("tmo.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("tmo.rdata", {16'd0, cpu_rdata}, 32'h0000_FFFF);
      cpu_read(3'd3);
      check("tmo.snap", {16'd0, cpu_rdata}, 32'h0000_FFFF);
`else
      check("wait.per_req", {31'd0, per_req}, 32'd1);
      check("wait.err", {31'd0, cpu_err}, 32'd0);
      repeat (20) tick();
      check("wait.per_req_long", {31'd0, per_req}, 32'd1);
      ack_cycle(32'h0F0F_F0F0);
      check("wait.rdata", {16'd0, cpu_rdata}, 32'h0000_0F0F);
      check("wait.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      cpu_read(3'd3);
      check("wait.snap", {16'd0, cpu_rdata}, 32'h0000_F0F0);
`endif

      // Reset in the middle of a read discards it.
      cpu_read(3'd6);
      check("rst_rd.per_req", {31'd0, per_req}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("rst_mid");
      ack_cycle(32'h1234_5678);
      check("rst_late_ack.per_req", {31'd0, per_req}, 32'd0);
      check("rst_late_ack.rvalid", {31'd0, cpu_rvalid}, 32'd0);
      cpu_read(3'd1);
      check("rst_snap.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("rst_snap.rdata", {16'd0, cpu_rdata}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
